boot_loader_ctrl: RTL and testbench



---
 rtl/boot_pkg.sv | 22 ++
 rtl/byte_word_packer.sv | 38 +++
 rtl/boot_loader_ctrl.sv | 154 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader controller.
// The CHK state exists only when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

    localparam int unsigned COUNT_W        = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        StCntLo     = 3'd0,
        StCntHi     = 3'd1,
        StData      = 3'd2,
        StWriteLast = 3'd3,
        StRun       = 3'd4,
        StError     = 3'd5
`ifdef BOOT_CHECKSUM_EN
        ,
        StChk       = 3'd6
`endif
    } boot_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian bytes into 32-bit words for the boot loader.
// word is only meaningful in the cycle word_done is high.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [1:0]  byte_idx,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  idx_q;
    logic [23:0] bytes_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            bytes_q <= '0;
        end else if (clear) begin
            idx_q   <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q != LAST_BYTE_IDX) begin
                bytes_q[8*idx_q +: 8] <= data;
            end
        end
    end

    // The final byte is merged combinationally so the word is ready on the 4th accept.
    assign byte_idx  = idx_q;
    assign word      = {data, bytes_q};
    assign word_done = accept && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: loads a counted little-endian word image into program memory, then
// releases the core. Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR            = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    input  logic        reload_i,
    output logic        pmem_we_o,
    output logic [31:0] pmem_addr_o,
    output logic [31:0] pmem_wdata_o,
    output logic        core_reset_o,
    output logic        done_o,
    output logic        error_o
);

    boot_state_e        state_q, state_d;
    logic [COUNT_W-1:0] count_q, word_idx_q, count_new;
    logic               accept, pk_accept, pk_clear, word_done, last_word, reload_go;
    logic [1:0]         byte_idx;
    logic [31:0]        word;

    assign accept    = rx_valid_i && rx_ready_o;
    assign pk_accept = accept && (state_q == StData);
    assign pk_clear  = (state_q != StData);
    assign count_new = {rx_data_i, count_q[7:0]};
    assign last_word = (word_idx_q == count_q - COUNT_W'(1));
    assign reload_go = reload_i && ((state_q == StRun) || (state_q == StError));

    byte_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear),
        .accept   (pk_accept),
        .data     (rx_data_i),
        .byte_idx (byte_idx),
        .word     (word),
        .word_done(word_done)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else if (state_q == StCntLo) begin
            chk_q <= '0;
        end else if (pk_accept) begin
            chk_q <= chk_q ^ rx_data_i;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCntLo;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCntLo: if (accept) state_d = StCntHi;
            StCntHi: begin
                if (accept) begin
                    if (32'(count_new) > PROGRAM_MEMORY_DEPTH) begin
                        state_d = StError;
                    end else if (count_new == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StRun;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (pk_accept && (byte_idx == LAST_BYTE_IDX) && last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StWriteLast;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    if (rx_data_i != chk_q)  state_d = StError;
                    else if (count_q == '0) state_d = StRun;
                    else                    state_d = StWriteLast;
                end
            end
`endif
            StWriteLast:    state_d = StRun;
            StRun, StError: if (reload_i) state_d = StCntLo;
            default:        state_d = StCntLo;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            word_idx_q   <= '0;
            pmem_we_o    <= 1'b0;
            pmem_addr_o  <= BASE_ADDR;
            pmem_wdata_o <= '0;
        end else begin
            pmem_we_o <= word_done;
            if ((state_q == StCntLo) && accept) count_q[7:0]  <= rx_data_i;
            if ((state_q == StCntHi) && accept) count_q[15:8] <= rx_data_i;
            if (word_done) begin
                pmem_addr_o  <= BASE_ADDR + 32'({word_idx_q, 2'b00});
                pmem_wdata_o <= word;
                word_idx_q   <= word_idx_q + COUNT_W'(1);
            end
            if (reload_go) begin
                count_q    <= '0;
                word_idx_q <= '0;
            end
        end
    end

    always_comb begin
        rx_ready_o   = 1'b0;
        core_reset_o = 1'b1;
        done_o       = 1'b0;
        error_o      = 1'b0;
        unique case (state_q)
            StCntLo, StCntHi, StData: rx_ready_o = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            StChk:                    rx_ready_o = 1'b1;
`endif
            StRun: begin
                core_reset_o = 1'b0;
                done_o       = 1'b1;
            end
            StError:                  error_o = 1'b1;
            default:                  ;
        endcase
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: expected writes are queued by the stimulus and
// popped by a monitor on every pmem_we_o pulse. Honours BOOT_CHECKSUM_EN.
module tb_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        reload_i;
    logic        pmem_we_o;
    logic [31:0] pmem_addr_o;
    logic [31:0] pmem_wdata_o;
    logic        core_reset_o;
    logic        done_o;
    logic        error_o;

    localparam logic [3:0] ST_LOAD  = 4'b1100; // {core_reset, rx_ready, done, error}
    localparam logic [3:0] ST_WLAST = 4'b1000;
    localparam logic [3:0] ST_RUN   = 4'b0010;
    localparam logic [3:0] ST_ERR   = 4'b1001;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .PROGRAM_MEMORY_DEPTH(64),
        .BASE_ADDR           (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .reload_i    (reload_i),
        .pmem_we_o   (pmem_we_o),
        .pmem_addr_o (pmem_addr_o),
        .pmem_wdata_o(pmem_wdata_o),
        .core_reset_o(core_reset_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    // Write monitor
    always @(negedge clk) begin
        if (!reset && pmem_we_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         pmem_addr_o, pmem_wdata_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({pmem_addr_o, pmem_wdata_o} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             pmem_addr_o, pmem_wdata_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic [3:0] exp);
        check(name, 32'({core_reset_o, rx_ready_o, done_o, error_o}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) step();
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && waited < 20) begin
            step();
            waited++;
        end
        if (!rx_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept_timeout: got rx_ready_o=0, expected 1 for byte %h", b);
        end else begin
            step();
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 0);
    endtask

    // Streams img (count + words [+ checksum]) and checks that RUN follows the last write.
    task automatic load_image(input int max_gap);
        logic [15:0] n;
        logic [7:0]  chk;
        logic [31:0] w;
        n   = 16'(img.size());
        chk = 8'h00;
        send_byte(n[7:0], pick_gap(max_gap));
        send_byte(n[15:8], pick_gap(max_gap));
        foreach (img[i]) begin
            exp_q.push_back({32'(4 * i), img[i]});
            w = img[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], pick_gap(max_gap));
                chk = chk ^ w[8*b +: 8];
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(chk, pick_gap(max_gap));
`endif
        if (n != 16'd0) begin
            check_status("held_during_last_write", ST_WLAST);
            step();
        end
        check_status("run_after_load", ST_RUN);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        step();
        reload_i = 1'b0;
        check_status("after_reload", ST_LOAD);
    endtask

    task automatic check_reset_values(input string name);
        check_status(name, ST_LOAD);
        check({name, "_we"}, 32'(pmem_we_o), 32'd0);
        check({name, "_addr"}, pmem_addr_o, 32'h0);
        check({name, "_wdata"}, pmem_wdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        reload_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        // Two-word image, back to back
        img = '{32'h0050_0513, 32'h00A0_0593};
        load_image(0);

        // Empty image goes straight to RUN without writes
        do_reload();
        img.delete();
        load_image(0);

        // Oversized count is rejected
        do_reload();
        send_raw('{8'h41, 8'h00});
        check_status("count_too_big", ST_ERR);
        step();
        check_status("error_ignores_input", ST_ERR);
        do_reload();

        // Same two-word image with random idle gaps
        img = '{32'h0050_0513, 32'h00A0_0593};
        load_image(5);

        // Reload from RUN, one-word image rewrites address 0
        do_reload();
        img = '{32'hDEAD_BEEF};
        load_image(0);

        // Full-depth image, last address 4*63
        do_reload();
        img.delete();
        for (int i = 0; i < 64; i++) img.push_back((32'h0101_0101 * i) ^ 32'hA500_003C);
        load_image(0);

        // Reset after 6 bytes abandons the image
        do_reload();
        exp_q.push_back({32'h0, 32'h0050_0513});
        send_raw('{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00});
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("midload_reset");
        step();
        reset = 1'b0;
        check_reset_values("midload_released");
        img = '{32'h1234_5678, 32'h9ABC_DEF0};
        load_image(2);

`ifdef BOOT_CHECKSUM_EN
        do_reload();
        exp_q.push_back({32'h0, 32'h4433_2211});
        send_raw('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
        step();
        check_status("checksum_match", ST_RUN);
        do_reload();
        exp_q.push_back({32'h0, 32'h4433_2211});
        send_raw('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
        check_status("checksum_mismatch", ST_ERR);
        step();
        check("checksum_write_kept", 32'(exp_q.size()), 32'd0);
`endif

        step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
